// File: rtl/imem_arbiter.sv
// Shares the combinational instruction memory between CPU fetch and a debug port,
// with a registered address stage, a registered data stage and a halt/drain handshake.
//
// state  | meaning
// RUN    | fetch and debug both arbitrated; fetch wins unless debug is forced
// DRAIN  | fetch frozen, waiting for the last fetch entry to leave stage 1
// HALTED | fetch frozen and no fetch traffic left; debug served every cycle
module imem_arbiter #(
   parameter int DEPTH_WORDS = 256,
   parameter int MAX_WAIT    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_ready,
   output logic        fetch_valid,
   output logic [31:0] fetch_inst,
   output logic        fetch_err,
   input  logic        dbg_req,
   input  logic [31:0] dbg_addr,
   output logic        dbg_ready,
   output logic        dbg_valid,
   output logic [31:0] dbg_data,
   output logic        dbg_err,
   input  logic        halt_req,
   output logic        halted,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_inst
);

   localparam int              WAIT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [32:0]     ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [WAIT_W-1:0]   w_wait_nxt;
   logic                w_dbg_force;
   logic                w_fetch_ready;
   logic                w_dbg_ready;
   logic                w_accept;
   logic [31:0]         w_sel_addr;
   logic                w_sel_err;

   logic                r_s1_valid;
   logic                r_s1_owner;   // 1 = debug
   logic [29:0]         r_s1_word;
   logic                r_s1_err;

   logic                r_fetch_valid;
   logic                r_fetch_err;
   logic [31:0]         r_fetch_inst;
   logic                r_dbg_valid;
   logic                r_dbg_err;
   logic [31:0]         r_dbg_data;

   // halt_req gates fetch directly so the first halt cycle already blocks new fetches
   always_comb begin
      w_dbg_force   = (r_wait_cnt >= WAIT_MAX);
      w_fetch_ready = fetch_req & (r_state == ST_RUN) & ~halt_req & ~(dbg_req & w_dbg_force);
      w_dbg_ready   = dbg_req & ~w_fetch_ready;
      w_accept      = w_fetch_ready | w_dbg_ready;
      w_sel_addr    = w_dbg_ready ? dbg_addr : fetch_addr;
      w_sel_err     = (|w_sel_addr[1:0]) | ({1'b0, w_sel_addr} >= ADDR_LIMIT);

      w_wait_nxt = r_wait_cnt;
      if (!dbg_req || w_dbg_ready) begin
         w_wait_nxt = '0;
      end else if (r_wait_cnt < WAIT_MAX) begin
         w_wait_nxt = r_wait_cnt + WAIT_W'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (halt_req) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!halt_req)                      w_state_nxt = ST_RUN;
            else if (!(r_s1_valid && !r_s1_owner)) w_state_nxt = ST_HALTED;
         end
         ST_HALTED: begin
            if (!halt_req) w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_valid <= 1'b0;
         r_s1_owner <= 1'b0;
         r_s1_word  <= '0;
         r_s1_err   <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_owner <= w_dbg_ready;
            r_s1_word  <= w_sel_addr[31:2];
            r_s1_err   <= w_sel_err;
         end
      end
   end

   // Data outputs only update on their owner's pulse and hold otherwise
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_valid <= 1'b0;
         r_fetch_err   <= 1'b0;
         r_fetch_inst  <= '0;
         r_dbg_valid   <= 1'b0;
         r_dbg_err     <= 1'b0;
         r_dbg_data    <= '0;
      end else begin
         r_fetch_valid <= r_s1_valid & ~r_s1_owner;
         r_fetch_err   <= r_s1_valid & ~r_s1_owner & r_s1_err;
         r_dbg_valid   <= r_s1_valid & r_s1_owner;
         r_dbg_err     <= r_s1_valid & r_s1_owner & r_s1_err;
         if (r_s1_valid && !r_s1_owner) r_fetch_inst <= r_s1_err ? '0 : mem_inst;
         if (r_s1_valid && r_s1_owner)  r_dbg_data   <= r_s1_err ? '0 : mem_inst;
      end
   end

   assign fetch_ready = w_fetch_ready;
   assign dbg_ready   = w_dbg_ready;
   assign fetch_valid = r_fetch_valid;
   assign fetch_err   = r_fetch_err;
   assign fetch_inst  = r_fetch_inst;
   assign dbg_valid   = r_dbg_valid;
   assign dbg_err     = r_dbg_err;
   assign dbg_data    = r_dbg_data;
   assign halted      = (r_state == ST_HALTED);
   assign mem_addr    = r_s1_valid ? {r_s1_word, 2'b00} : 32'd0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, hand-written halt/starvation/reset
// sequences, and a randomized run against a transaction-level reference model.
module tb_imem_arbiter;

   localparam int DEPTH_WORDS = 256;
   localparam int MAX_WAIT    = 4;
   localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_req = 1'b0, dbg_req = 1'b0, halt_req = 1'b0;
   logic [31:0] fetch_addr = '0, dbg_addr = '0;
   logic        fetch_ready, fetch_valid, fetch_err;
   logic        dbg_ready, dbg_valid, dbg_err, halted;
   logic [31:0] fetch_inst, dbg_data, mem_addr, mem_inst;

   logic [31:0] mem_img [DEPTH_WORDS];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign mem_inst = (mem_addr < 32'(4 * DEPTH_WORDS)) ? mem_img[mem_addr[9:2]] : 32'hDEAD_BEEF;

   imem_arbiter #(.DEPTH_WORDS(DEPTH_WORDS), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_err(fetch_err),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ready(dbg_ready),
      .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_err(dbg_err),
      .halt_req(halt_req), .halted(halted),
      .mem_addr(mem_addr), .mem_inst(mem_inst)
   );

   typedef struct {
      logic        fq;
      logic [31:0] fa;
      logic        dq;
      logic [31:0] da;
      logic        efr;
      logic        edr;
      logic [31:0] ema;
      logic        efv;
      logic [31:0] efi;
      logic        efe;
      logic        edv;
      logic [31:0] edd;
      logic        ede;
   } vec_t;

   typedef struct {
      int          due;
      logic        owner;
      logic [31:0] addr;
      logic        err;
      logic [31:0] data;
   } resp_t;

   vec_t  vecs [16];
   resp_t pend [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic efr, input logic edr,
                            input logic [31:0] ema, input logic efv, input logic [31:0] efi,
                            input logic efe, input logic edv, input logic [31:0] edd,
                            input logic ede, input logic eh);
      chk1({tag, " fetch_ready"}, fetch_ready, efr);
      chk1({tag, " dbg_ready"},   dbg_ready,   edr);
      chk ({tag, " mem_addr"},    mem_addr,    ema);
      chk1({tag, " fetch_valid"}, fetch_valid, efv);
      chk ({tag, " fetch_inst"},  fetch_inst,  efi);
      chk1({tag, " fetch_err"},   fetch_err,   efe);
      chk1({tag, " dbg_valid"},   dbg_valid,   edv);
      chk ({tag, " dbg_data"},    dbg_data,    edd);
      chk1({tag, " dbg_err"},     dbg_err,     ede);
      chk1({tag, " halted"},      halted,      eh);
   endtask

   task automatic drive(input logic fq, input logic [31:0] fa, input logic dq,
                        input logic [31:0] da, input logic hq);
      fetch_req = fq; fetch_addr = fa; dbg_req = dq; dbg_addr = da; halt_req = hq;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic vec_t mk(input logic fq, input logic [31:0] fa, input logic dq,
                               input logic [31:0] da, input logic efr, input logic edr,
                               input logic [31:0] ema, input logic efv, input logic [31:0] efi,
                               input logic efe, input logic edv, input logic [31:0] edd,
                               input logic ede);
      vec_t v;
      v.fq = fq; v.fa = fa; v.dq = dq; v.da = da; v.efr = efr; v.edr = edr; v.ema = ema;
      v.efv = efv; v.efi = efi; v.efe = efe; v.edv = edv; v.edd = edd; v.ede = ede;
      return v;
   endfunction

   function automatic logic [31:0] rand_addr();
      int unsigned s;
      s = $urandom_range(0, 9);
      if (s < 7)       return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      else if (s == 7) return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else if (s == 8) return 32'(4 * DEPTH_WORDS) + 32'($urandom_range(0, 4095) * 4);
      else             return $urandom;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] i0, i1, m2, m3, m4;
      logic        fq, dq, hq, e_fr, e_dr, force_d, s1_fetch;
      logic [31:0] fa, da, e_ma, last_fi, last_dd, a;
      logic        e_fv, e_dv, e_fe, e_de;
      int          m_mode, m_wait;
      resp_t       r, nr;

      for (int i = 0; i < DEPTH_WORDS; i++)
         mem_img[i] = {8'(i), 8'hA5, ~8'(i), 8'h3C};
      mem_img[0] = 32'h2004_0003;
      mem_img[1] = 32'h0C00_0003;
      i0 = mem_img[0]; i1 = mem_img[1]; m2 = mem_img[2]; m3 = mem_img[3]; m4 = mem_img[4];

      //        fq fa      dq da       fr dr ma      fv fi  fe dv dd  de
      vecs[0]  = mk(1, 32'h0,  0, 32'h0,   1, 0, 32'h0,   0, 0,  0, 0, 0,  0);
      vecs[1]  = mk(1, 32'h4,  0, 32'h0,   1, 0, 32'h0,   0, 0,  0, 0, 0,  0);
      vecs[2]  = mk(0, 32'h0,  0, 32'h0,   0, 0, 32'h4,   1, i0, 0, 0, 0,  0);
      vecs[3]  = mk(0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   1, i1, 0, 0, 0,  0);
      vecs[4]  = mk(0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   0, i1, 0, 0, 0,  0);
      vecs[5]  = mk(1, 32'h2,  0, 32'h0,   1, 0, 32'h0,   0, i1, 0, 0, 0,  0);
      vecs[6]  = mk(0, 32'h0,  1, 32'h400, 0, 1, 32'h0,   0, i1, 0, 0, 0,  0);
      vecs[7]  = mk(0, 32'h0,  0, 32'h0,   0, 0, 32'h400, 1, 0,  1, 0, 0,  0);
      vecs[8]  = mk(0, 32'h0,  1, 32'h8,   0, 1, 32'h0,   0, 0,  0, 1, 0,  1);
      vecs[9]  = mk(0, 32'h0,  0, 32'h0,   0, 0, 32'h8,   0, 0,  0, 0, 0,  0);
      vecs[10] = mk(0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   0, 0,  0, 1, m2, 0);
      vecs[11] = mk(0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   0, 0,  0, 0, m2, 0);
      vecs[12] = mk(1, 32'hC,  1, 32'h10,  1, 0, 32'h0,   0, 0,  0, 0, m2, 0);
      vecs[13] = mk(0, 32'h0,  1, 32'h10,  0, 1, 32'hC,   0, 0,  0, 0, m2, 0);
      vecs[14] = mk(0, 32'h0,  0, 32'h0,   0, 0, 32'h10,  1, m3, 0, 0, m2, 0);
      vecs[15] = mk(0, 32'h0,  0, 32'h0,   0, 0, 32'h0,   0, m3, 0, 1, m4, 0);

      // Reset values, checked while reset is still asserted
      @(negedge clk);
      #1;
      check_all("reset", 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].fq, vecs[i].fa, vecs[i].dq, vecs[i].da, 1'b0);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].efr, vecs[i].edr, vecs[i].ema, vecs[i].efv,
                   vecs[i].efi, vecs[i].efe, vecs[i].edv, vecs[i].edd, vecs[i].ede, 1'b0);
         @(negedge clk);
      end

      // Starvation: fetch saturates the port, debug must be forced through
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 32'h20 + 32'(4 * k), (k <= 4), 32'h4, 1'b0);
         #1;
         if (k <= 4) chk1($sformatf("starve k%0d dbg_ready", k), dbg_ready, (k == 4));
         chk1($sformatf("starve k%0d fetch_ready", k), fetch_ready, (k != 4));
         if (k == 6) begin
            chk1("starve dbg_valid", dbg_valid, 1'b1);
            chk ("starve dbg_data", dbg_data, 32'h0C00_0003);
            chk1("starve fetch_valid gap", fetch_valid, 1'b0);
         end
         @(negedge clk);
      end

      // Halt handshake with continuous fetch, debug read while halted, resume
      do_reset();
      for (int k = 0; k < 14; k++) begin
         drive(1'b1, 32'(4 * k), (k == 8), 32'h4, (k >= 5 && k <= 10));
         #1;
         chk1($sformatf("halt k%0d fetch_ready", k), fetch_ready, (k < 5 || k >= 12));
         if (k == 6) begin
            chk1("halt last fetch_valid", fetch_valid, 1'b1);
            chk ("halt last fetch_inst", fetch_inst, mem_img[4]);
            chk1("halt k6 halted", halted, 1'b0);
         end
         if (k == 7) begin
            chk1("halt k7 fetch_valid", fetch_valid, 1'b0);
            chk1("halt k7 halted", halted, 1'b1);
         end
         if (k == 8)  chk1("halt dbg_ready", dbg_ready, 1'b1);
         if (k == 10) begin
            chk1("halt dbg_valid", dbg_valid, 1'b1);
            chk ("halt dbg_data", dbg_data, 32'h0C00_0003);
         end
         if (k == 11) chk1("halt k11 halted", halted, 1'b1);
         if (k == 12) chk1("halt k12 halted", halted, 1'b0);
         @(negedge clk);
      end

      // Asynchronous reset with two fetches in flight
      do_reset();
      drive(1'b1, 32'h0, 1'b0, '0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h4, 1'b0, '0, 1'b0);
      @(negedge clk);
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      #1;
      chk1("areset pre fetch_valid", fetch_valid, 1'b1);
      chk ("areset pre mem_addr", mem_addr, 32'h4);
      #1;
      reset = 1'b0;
      #1;
      check_all("areset", 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk1($sformatf("areset post j%0d fetch_valid", j), fetch_valid, 1'b0);
         chk1($sformatf("areset post j%0d dbg_valid", j), dbg_valid, 1'b0);
         @(negedge clk);
      end
      drive(1'b1, 32'h0, 1'b0, '0, 1'b0);
      #1;
      chk1("areset single fetch_ready", fetch_ready, 1'b1);
      @(negedge clk);
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      #1;
      chk ("areset single mem_addr", mem_addr, 32'h0);
      chk1("areset single early valid", fetch_valid, 1'b0);
      @(negedge clk);
      #1;
      chk1("areset single fetch_valid", fetch_valid, 1'b1);
      chk ("areset single fetch_inst", fetch_inst, 32'h2004_0003);
      chk1("areset single fetch_err", fetch_err, 1'b0);
      @(negedge clk);

      // Randomized run against a transaction-level model
      do_reset();
      m_mode = M_RUN; m_wait = 0; last_fi = '0; last_dd = '0;
      pend.delete();
      fq = 1'b0; dq = 1'b0; hq = 1'b0; e_fr = 1'b0; e_dr = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!(fq && !e_fr)) fq = ($urandom_range(0, 9) < 7);
         if (!(dq && !e_dr)) dq = ($urandom_range(0, 9) < 3);
         fa = rand_addr();
         da = rand_addr();
         if ($urandom_range(0, 15) == 0) hq = ~hq;
         drive(fq, fa, dq, da, hq);
         #1;

         force_d = (m_wait >= MAX_WAIT);
         e_fr = fq && (m_mode == M_RUN) && !hq && !(dq && force_d);
         e_dr = dq && !e_fr;

         e_fv = 1'b0; e_dv = 1'b0; e_fe = 1'b0; e_de = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            if (r.owner) begin e_dv = 1'b1; e_de = r.err; last_dd = r.data; end
            else         begin e_fv = 1'b1; e_fe = r.err; last_fi = r.data; end
         end
         e_ma = '0;
         s1_fetch = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            e_ma = {pend[0].addr[31:2], 2'b00};
            s1_fetch = !pend[0].owner;
         end

         check_all($sformatf("rand c%0d", cyc), e_fr, e_dr, e_ma, e_fv, last_fi, e_fe,
                   e_dv, last_dd, e_de, (m_mode == M_HALTED));

         if (e_fr || e_dr) begin
            a = e_dr ? da : fa;
            nr.due = cyc + 2; nr.owner = e_dr; nr.addr = a;
            nr.err = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH_WORDS));
            nr.data = nr.err ? 32'h0 : mem_img[a[9:2]];
            pend.push_back(nr);
         end
         if (!dq || e_dr)            m_wait = 0;
         else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
         case (m_mode)
            M_RUN:    if (hq) m_mode = M_DRAIN;
            M_DRAIN:  if (!hq) m_mode = M_RUN; else if (!s1_fetch) m_mode = M_HALTED;
            default:  if (!hq) m_mode = M_RUN;
         endcase
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
